// File: rtl/alu_8bit.sv
// ---------------------------------------------------------------------------
// alu_8bit
// Registered 8-bit arithmetic/logic unit used as a single-cycle execution
// stage. One of 16 operations is applied to two unsigned 8-bit operands. The
// 16-bit result is captured into d_out on each rising clock edge where en is
// high. When en is low, d_out holds its value.
//
// Ports
//   clk    in   1   rising-edge clock
//   rst    in   1   asynchronous active-high reset; clears d_out
//   a_in   in   8   operand A (unsigned)
//   b_in   in   8   operand B (unsigned)
//   co_in  in   4   opcode
//   en     in   1   load enable for the result register
//   d_out  out 16   registered result
// ---------------------------------------------------------------------------
module alu_8bit (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  a_in,
    input  logic [7:0]  b_in,
    input  logic [3:0]  co_in,
    input  logic        en,
    output logic [15:0] d_out
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_INC  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_DEC  = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_DIV  = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_SHR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_INV  = 4'b1010;
    localparam logic [3:0] OP_NAND = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1101;
    localparam logic [3:0] OP_XNOR = 4'b1110;
    localparam logic [3:0] OP_BUF  = 4'b1111;

    // Division saturates to all-ones when the divisor is zero.
    function automatic logic [15:0] div_sat(input logic [7:0] num, input logic [7:0] den);
        logic [15:0] q;
        if (den == 8'd0) begin
            q = 16'hFFFF;
        end else begin
            q = {8'h00, num / den};
        end
        return q;
    endfunction

    // Zero-extend an 8-bit logic result; the upper byte is always cleared,
    // including for inverting operations.
    function automatic logic [15:0] zext8(input logic [7:0] v);
        return {8'h00, v};
    endfunction

    logic [15:0] a_w;
    logic [15:0] b_w;
    logic [15:0] result_p0;

    assign a_w = zext8(a_in);
    assign b_w = zext8(b_in);

    // Stage 0: combinational result from the current operands and opcode.
    // SUB and DEC wrap modulo 2^16 naturally in the 16-bit datapath.
    always_comb begin
        result_p0 = 16'h0000;
        case (co_in)
            OP_ADD:  result_p0 = a_w + b_w;
            OP_INC:  result_p0 = a_w + 16'd1;
            OP_SUB:  result_p0 = a_w - b_w;
            OP_DEC:  result_p0 = a_w - 16'd1;
            OP_MUL:  result_p0 = a_w * b_w;
            OP_DIV:  result_p0 = div_sat(a_in, b_in);
            OP_SHL:  result_p0 = {7'b0, a_in, 1'b0};
            OP_SHR:  result_p0 = {9'b0, a_in[7:1]};
            OP_AND:  result_p0 = zext8(a_in & b_in);
            OP_OR:   result_p0 = zext8(a_in | b_in);
            OP_INV:  result_p0 = zext8(~a_in);
            OP_NAND: result_p0 = zext8(~(a_in & b_in));
            OP_NOR:  result_p0 = zext8(~(a_in | b_in));
            OP_XOR:  result_p0 = zext8(a_in ^ b_in);
            OP_XNOR: result_p0 = zext8(~(a_in ^ b_in));
            OP_BUF:  result_p0 = a_w;
            default: result_p0 = 16'h0000;
        endcase
    end

    // Stage 1: result register. Reset clears it asynchronously and has
    // priority over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out <= 16'h0000;
        end else if (en) begin
            d_out <= result_p0;
        end
    end

endmodule

// File: tb/tb_alu_8bit.sv
// ---------------------------------------------------------------------------
// tb_alu_8bit
// Self-checking bench for alu_8bit: reset behaviour, opcode sweep over small
// operands, width corners, enable gating and back-to-back opcode changes.
// ---------------------------------------------------------------------------
module tb_alu_8bit;

    logic        clk;
    logic        rst;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic [3:0]  co_in;
    logic        en;
    logic [15:0] d_out;

    int n_checks;
    int n_fail;

    alu_8bit dut (
        .clk   (clk),
        .rst   (rst),
        .a_in  (a_in),
        .b_in  (b_in),
        .co_in (co_in),
        .en    (en),
        .d_out (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Drive one operation and advance past the next rising edge.
    task automatic apply(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        co_in = op;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
    endtask

    // Reference opcode table evaluated with integer arithmetic.
    function automatic logic [15:0] model(input int op, input int a, input int b);
        int r;
        case (op)
            0:  r = a + b;
            1:  r = a + 1;
            2:  r = (a - b) & 'hFFFF;
            3:  r = (a - 1) & 'hFFFF;
            4:  r = a * b;
            5:  r = (b == 0) ? 'hFFFF : a / b;
            6:  r = a * 2;
            7:  r = a / 2;
            8:  r = a & b;
            9:  r = a | b;
            10: r = 255 - a;
            11: r = 255 - (a & b);
            12: r = 255 - (a | b);
            13: r = a ^ b;
            14: r = 255 - (a ^ b);
            default: r = a;
        endcase
        return 16'(r);
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        en    = 1'b0;
        a_in  = 8'h00;
        b_in  = 8'h00;
        co_in = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_value", d_out, 16'h0000);
        rst = 1'b0;
        en  = 1'b1;

        // Load 0x0123, then assert reset between edges
        apply(4'b0000, 8'hFF, 8'h24);
        check("preload_0123", d_out, 16'h0123);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", d_out, 16'h0000);
        apply(4'b0000, 8'd5, 8'd6);
        check("reset_over_en_1", d_out, 16'h0000);
        apply(4'b0000, 8'd5, 8'd6);
        check("reset_over_en_2", d_out, 16'h0000);
        rst = 1'b0;
        apply(4'b0000, 8'd5, 8'd6);
        check("first_post_reset", d_out, 16'd11);

        // Named sweep points, hand-computed
        apply(4'b0010, 8'd3, 8'd5);     check("sub_3_5", d_out, 16'hFFFE);
        apply(4'b0011, 8'd0, 8'd0);     check("dec_0", d_out, 16'hFFFF);
        apply(4'b0101, 8'd7, 8'd0);     check("div_7_0", d_out, 16'hFFFF);
        apply(4'b1010, 8'd0, 8'd0);     check("inv_0", d_out, 16'h00FF);
        apply(4'b1110, 8'd15, 8'd15);   check("xnor_15_15", d_out, 16'h00FF);

        // Sweep a, b in 0..15 across all opcodes, back to back
        for (int op = 0; op < 16; op++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    apply(4'(op), 8'(a), 8'(b));
                    check($sformatf("sweep_op%0d_a%0d_b%0d", op, a, b), d_out, model(op, a, b));
                end
            end
        end

        // Width corners
        apply(4'b0000, 8'd255, 8'd255); check("add_255_255", d_out, 16'h01FE);
        apply(4'b0100, 8'd255, 8'd255); check("mul_255_255", d_out, 16'hFE01);
        apply(4'b0001, 8'd255, 8'd0);   check("inc_255", d_out, 16'h0100);
        apply(4'b0110, 8'h80, 8'd0);    check("shl_80", d_out, 16'h0100);
        apply(4'b0111, 8'h01, 8'd0);    check("shr_01", d_out, 16'h0000);
        apply(4'b0101, 8'd200, 8'd7);   check("div_200_7", d_out, 16'd28);
        apply(4'b1100, 8'hA5, 8'h0F);   check("nor_upper_zero", d_out, 16'h0050);
        apply(4'b1111, 8'hC3, 8'h11);   check("buf_c3", d_out, 16'h00C3);

        // Enable gating
        apply(4'b0000, 8'd27, 8'd18);   check("en_load_45", d_out, 16'd45);
        en = 1'b0;
        apply(4'b0000, 8'd21, 8'd11);   check("en_hold_1", d_out, 16'd45);
        apply(4'b0100, 8'd9, 8'd9);     check("en_hold_2", d_out, 16'd45);
        apply(4'b1010, 8'd0, 8'd3);     check("en_hold_3", d_out, 16'd45);
        apply(4'b0000, 8'd21, 8'd11);   check("en_hold_4", d_out, 16'd45);
        en = 1'b1;
        apply(4'b0000, 8'd21, 8'd11);   check("en_reload_32", d_out, 16'd32);

        // Opcode change every cycle
        for (int i = 0; i < 3; i++) begin
            apply(4'b0100, 8'd12, 8'd12); check($sformatf("alt_mul_%0d", i), d_out, 16'd144);
            apply(4'b1100, 8'hF0, 8'h0F); check($sformatf("alt_nor_%0d", i), d_out, 16'h0000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
